// File: rtl/storage_readout_ctrl_if.sv
// Purpose: host/storage-facing signal bundle of the capture-storage readout controller.
// Latency: none; wiring only.
// Backpressure: out_ready from downstream gates rden combinationally inside the controller.
// Ports: start/abort/ch_mask/sample_count come from the host, fifo_empty from storage, and
// out_ready from downstream. rden goes to storage. dout_valid/dout_ch tag the storage dout.
// busy/done/underrun report status back to the host.
interface storage_readout_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [7:0]       ch_mask;
  logic [CNT_W-1:0] sample_count;
  logic [7:0]       fifo_empty;
  logic             out_ready;
  logic [7:0]       rden;
  logic             dout_valid;
  logic [2:0]       dout_ch;
  logic             busy;
  logic             done;
  logic [7:0]       underrun;

  // Host / storage / downstream side.
  modport master (
    output start, abort, ch_mask, sample_count, fifo_empty, out_ready,
    input  rden, dout_valid, dout_ch, busy, done, underrun
  );

  // Readout controller side.
  modport slave (
    input  start, abort, ch_mask, sample_count, fifo_empty, out_ready,
    output rden, dout_valid, dout_ch, busy, done, underrun
  );
endinterface

// File: rtl/storage_readout_ctrl.sv
// Purpose: walks the enabled capture channels in ascending order, reading sample_count words from each.
// Latency: a word read in cycle t is tagged on dout_valid/dout_ch in cycle t+RD_LAT. Channel changes cost one idle cycle.
// Backpressure: rden drops in the same cycle out_ready falls. Up to RD_LAT words are still in flight.
// Ports: rdclk is the clock and rst is a synchronous active-high reset. bus is the slave modport of
// storage_readout_ctrl_if. It carries the host controls, the storage flags/enables and the output tags.
module storage_readout_ctrl #(
  parameter int RD_LAT  = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 rdclk,
  input  logic                 rst,
  storage_readout_ctrl_if.slave bus
);
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The drain counter only needs to count 0 .. RD_LAT-1.
  localparam int DR_W = (RD_LAT < 3) ? 1 : $clog2(RD_LAT);

  typedef enum logic [2:0] {IDLE, SEL, RD, DRAIN, DONE} state_t;

  state_t           state, stateNext;
  logic [7:0]       remMask;
  logic [CNT_W-1:0] countLat;
  logic [CNT_W-1:0] sampleCnt;
  logic [TO_W-1:0]  toCnt;
  logic [DR_W-1:0]  drainCnt;
  logic [2:0]       curCh;
  logic [7:0]       underrunQ;
  logic             pipeVld [RD_LAT];
  logic [2:0]       pipeCh  [RD_LAT];

  logic [2:0]       lowCh;
  logic [7:0]       rdenC;
  logic             issue;
  logic             emptyTick;
  logic             cntHit;
  logic             toHit;
  logic             startOk;

  // Lowest set bit of the channels still to be dumped.
  always_comb begin
    lowCh = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (remMask[i]) lowCh = 3'(i);
    end
  end

  assign startOk = bus.start && (bus.ch_mask != 8'd0) && (bus.sample_count != '0);

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    emptyTick = 1'b0;
    cntHit    = 1'b0;
    toHit     = 1'b0;
    rdenC     = 8'd0;
    case (state)
      IDLE:  if (bus.start) stateNext = startOk ? SEL : DONE;
      SEL:   stateNext = RD;
      RD: begin
        issue     = bus.out_ready && !bus.fifo_empty[curCh] && (sampleCnt < countLat);
        emptyTick = bus.out_ready && bus.fifo_empty[curCh];
        // Leave on the edge after the last read so only the SEL cycle separates channels.
        cntHit    = issue && ((sampleCnt + CNT_W'(1)) == countLat);
        toHit     = emptyTick && ((toCnt + TO_W'(1)) == TO_W'(TIMEOUT));
        if (cntHit || toHit) stateNext = (remMask != 8'd0) ? SEL : DRAIN;
        if (issue) rdenC[curCh] = 1'b1;
      end
      DRAIN: if (drainCnt == DR_W'(RD_LAT - 1)) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Abort overrides any transition out of an active read phase.
    if (bus.abort && ((state == SEL) || (state == RD))) stateNext = DRAIN;
  end

  always_ff @(posedge rdclk) begin
    if (rst) begin
      state     <= IDLE;
      remMask   <= 8'd0;
      countLat  <= '0;
      sampleCnt <= '0;
      toCnt     <= '0;
      drainCnt  <= '0;
      curCh     <= 3'd0;
      underrunQ <= 8'd0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipeVld[i] <= 1'b0;
        pipeCh[i]  <= 3'd0;
      end
    end else begin
      state <= stateNext;
      if ((state == IDLE) && bus.start) begin
        underrunQ <= 8'd0;
        remMask   <= bus.ch_mask;
        countLat  <= bus.sample_count;
      end
      if (state == SEL) begin
        curCh          <= lowCh;
        remMask[lowCh] <= 1'b0;
        sampleCnt      <= '0;
        toCnt          <= '0;
      end
      // issue and emptyTick are mutually exclusive; out_ready low holds the timeout count.
      if (issue) begin
        sampleCnt <= sampleCnt + CNT_W'(1);
        toCnt     <= '0;
      end else if (emptyTick) begin
        toCnt <= toCnt + TO_W'(1);
      end
      if (toHit) underrunQ[curCh] <= 1'b1;
      drainCnt <= (state == DRAIN) ? drainCnt + DR_W'(1) : '0;
      // Tag pipe follows the read regardless of later state changes.
      pipeVld[0] <= issue;
      pipeCh[0]  <= curCh;
      for (int i = 1; i < RD_LAT; i++) begin
        pipeVld[i] <= pipeVld[i-1];
        pipeCh[i]  <= pipeCh[i-1];
      end
    end
  end

  assign bus.rden       = rdenC;
  assign bus.dout_valid = pipeVld[RD_LAT-1];
  assign bus.dout_ch    = pipeCh[RD_LAT-1];
  assign bus.busy       = (state == SEL) || (state == RD) || (state == DRAIN);
  assign bus.done       = (state == DONE);
  assign bus.underrun   = underrunQ;
endmodule
